rr_bus_arbiter4: RTL and testbench
==================================

# rr_bus_arbiter4

Four-way round-robin arbiter that shares one 32-bit datapath resource (a shared memory port or write-back bus) among four requesters. It drives a registered 2-bit select for a 32-bit 4:1 datapath mux, gives the granted requester the bus for a fixed number of cycles, and returns a completion pulse. It sits between the pipeline-stage requesters and the shared port.

## Interface
- `LATENCY`, default 2: cycles the bus is held per transaction; legal range 1..15.
- `LOCK_MAX`, default 4: maximum consecutive locked transactions per requester; legal range 1..15. Used only with `ARB_LOCK_EN`.
- `Clk`  in  1: clock; all state updates on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Req`  in  4: request per requester; must be held until that requester's `Done`.
- `Lock`  in  4: per-requester bus-lock request; ignored without `ARB_LOCK_EN`.
- `InA`, `InB`, `InC`, `InD`  in  32 each: requester 0..3 payload.
- `Grant`  out  4: one-hot grant, registered.
- `Sel`  out  2: registered mux select, equal to the granted index.
- `Out`  out  32: payload selected by `Sel` (combinational from `Sel`).
- `Done`  out  4: one-cycle completion pulse for the granted requester.
- `Busy`  out  1: high while any grant is active.

## Operation
- States are IDLE and HOLD.
- Internal registers:
  - `Cnt`: 4-bit transaction countdown.
  - `Ptr`: 2-bit round-robin pointer.
  - `Idx`: 2-bit current owner.
  - `LockCnt`: 4-bit consecutive-lock counter.
- Pick function: the first index `i` in the order `Ptr`, `Ptr+1`, `Ptr+2`, `Ptr+3` (mod 4) with `Req[i]=1`.
- **IDLE**
  - `Grant=0`, `Busy=0`, `Done=0`.
  - If any `Req` bit is set: go to HOLD with `Idx`=pick, `Sel`=pick, `Grant`=one-hot(pick), `Cnt`=`LATENCY-1`, `LockCnt`=0.
- **HOLD**
  - `Busy=1`.
  - While `Cnt!=0`, decrement `Cnt`.
  - When `Cnt==0`, assert `Done[Idx]` for that cycle and set `Ptr <= Idx+1` (wraps 3 to 0). Then:
    1. If a lock continuation applies (see Configuration): stay in HOLD with the same `Idx`, reload `Cnt`, and increment `LockCnt`.
    2. Else if any `Req` bit is set: re-pick using the updated pointer (`Idx+1`) and stay in HOLD with the new owner. There is no idle bubble.
    3. Else: go to IDLE. `Grant` becomes 0.
- `Req` is sampled only at arbitration. Dropping `Req` mid-transaction does not shorten the grant; the transaction completes and `Done` still pulses.
- `Sel` keeps its last value in IDLE, so `Out` shows the last selected payload.
- Reset values: state IDLE, `Grant=0`, `Sel=0`, `Done=0`, `Busy=0`, `Ptr=0`, `Cnt=0`, `Idx=0`, `LockCnt=0`. `Out` follows `InA`.
- Reset during HOLD aborts the transaction. No `Done` is issued.

## Timing
- `Req` first seen in IDLE in cycle N: `Grant` and `Sel` are valid in cycles N+1 through N+`LATENCY`.
- `Done` is asserted in cycle N+`LATENCY`, the last grant cycle. With `LATENCY=1`, `Done` coincides with the first grant cycle.
- Back-to-back transactions: the next owner's grant starts in cycle N+`LATENCY`+1.
- Steady contention by all four requesters gives grant order 0, 1, 2, 3, 0 with no gaps. Each requester waits at most 3×`LATENCY` cycles.
- `Grant`, `Sel`, `Busy` and `Done` are registered or state-decoded, with no combinational path from `Req`. `Out` is combinational from `Sel` and the inputs.

## Configuration
- Macro: `ARB_LOCK_EN`.
- When defined, a lock continuation applies at `Cnt==0` if all of the following hold:
  - `Lock[Idx]=1`
  - `Req[Idx]=1`
  - `LockCnt < LOCK_MAX-1`
- During a lock continuation `Ptr` is still updated, so round-robin resumes correctly after the lock ends. Once `LockCnt` reaches `LOCK_MAX-1`, re-arbitration is forced.
- When not defined: the `Lock` port exists but is ignored, `LockCnt` is not implemented, and every completion re-arbitrates.

## Structure
- Shared package `arb_pkg` holds:
  - the state encoding (IDLE=0, HOLD=1);
  - the counter width constant `ARB_CNT_W=4`;
  - the requester count constant `ARB_N=4`.
- One natural sub-module, `rr_priority_pick`: combinational. Inputs are `Req[3:0]` and `Ptr[1:0]`; outputs are pick index `[1:0]` and `any`.
- The 32-bit 4:1 output mux is a plain case on `Sel` inside the top level.

## Test plan
- **Reset mid-HOLD:** `Reset` pulse during HOLD with `LATENCY=3` and `Cnt=1` -> next cycle `Grant=0`, `Busy=0`, `Sel=0`, no `Done` pulse.
- **Single request:** `LATENCY=2`, `Req=0100` from cycle 1 -> `Grant=0100` and `Sel=2` in cycles 2–3, `Done=0100` in cycle 3, IDLE in cycle 4. `Out` equals `InC`, e.g. 0xDEADBEEF.
- **Full contention:** `Req=1111` held, `LATENCY=1`, from reset -> grants 0001, 0010, 0100, 1000, 0001 in consecutive cycles, one `Done` per cycle, `Busy` continuously high.
- **Early drop and pointer wrap:** `Req=1001`, requester 3 drops `Req` mid-grant -> its grant still lasts `LATENCY` cycles with `Done[3]`. The pointer wraps to 0 and requester 0 is granted next.
- **Lock (with `ARB_LOCK_EN`):** `LOCK_MAX=4`, `Req=0011`, `Lock=0001` -> requester 0 completes 4 consecutive transactions, then requester 1 is granted. Without the macro, grants alternate 0, 1, 0, 1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter.
// Covers the state encoding, the counter width, the requester count and a one-hot helper.
package arb_pkg;

  localparam int ARB_CNT_W = 4;
  localparam int ARB_N     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  function automatic logic [ARB_N-1:0] onehot4(input logic [1:0] i);
    return ARB_N'(1) << i;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first requester at or after ptr (mod 4). Purely combinational.
// There is no backpressure. 'any' is low when no request bit is set.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       pick,
  output logic             any
);

  // Scan from the farthest offset down, so the nearest set request wins.
  always_comb begin
    pick = 2'd0;
    any  = 1'b0;
    for (int k = ARB_N - 1; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick = ptr + 2'(k);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// Four-way round-robin arbiter. It holds a 32-bit shared bus for LATENCY cycles per grant and pulses Done on the last cycle.
// Back-to-back grants have no bubble. Build with ARB_LOCK_EN to let a locked owner keep the bus for up to LOCK_MAX transactions.
module rr_bus_arbiter4
  import arb_pkg::*;
#(
  parameter int LATENCY  = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [ARB_N-1:0] Req,
  input  logic [ARB_N-1:0] Lock,
  input  logic [31:0]      InA,
  input  logic [31:0]      InB,
  input  logic [31:0]      InC,
  input  logic [31:0]      InD,
  output logic [ARB_N-1:0] Grant,
  output logic [1:0]       Sel,
  output logic [31:0]      Out,
  output logic [ARB_N-1:0] Done,
  output logic             Busy
);

  localparam logic [ARB_CNT_W-1:0] CNT_LOAD = ARB_CNT_W'(LATENCY - 1);

  arb_state_t           state, state_nxt;
  logic [ARB_CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]           ptr, ptr_nxt;
  logic [1:0]           idx, idx_nxt;
  logic [1:0]           pick_ptr, pick_idx;
  logic                 pick_any;
  logic                 lock_go;
  logic                 last_cycle;

  assign last_cycle = (state == HOLD) && (cnt == '0);

  // On a completion the pointer has already moved past the finishing owner.
  assign pick_ptr = (state == HOLD) ? idx + 2'd1 : ptr;

  rr_priority_pick u_pick (
    .req  (Req),
    .ptr  (pick_ptr),
    .pick (pick_idx),
    .any  (pick_any)
  );

`ifdef ARB_LOCK_EN
  localparam logic [ARB_CNT_W-1:0] LOCK_LAST = ARB_CNT_W'(LOCK_MAX - 1);
  logic [ARB_CNT_W-1:0] lock_cnt;

  assign lock_go = Lock[idx] && Req[idx] && (lock_cnt < LOCK_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lock_cnt <= '0;
    end else if (last_cycle) begin
      lock_cnt <= lock_go ? lock_cnt + 1'b1 : '0;
    end else if (state == IDLE) begin
      lock_cnt <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^{Lock, 4'(LOCK_MAX)};
  assign lock_go     = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 2'd0;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = HOLD;
          idx_nxt   = pick_idx;
          cnt_nxt   = CNT_LOAD;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          ptr_nxt = idx + 2'd1;
          if (lock_go) begin
            cnt_nxt = CNT_LOAD;
          end else if (pick_any) begin
            idx_nxt = pick_idx;
            cnt_nxt = CNT_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  assign Busy  = (state == HOLD);
  assign Grant = Busy ? onehot4(idx) : '0;
  assign Done  = last_cycle ? onehot4(idx) : '0;
  assign Sel   = idx;

  always_comb begin
    case (Sel)
      2'd0:    Out = InA;
      2'd1:    Out = InB;
      2'd2:    Out = InC;
      default: Out = InD;
    endcase
  end

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Random-stimulus bench for rr_bus_arbiter4. A transaction-level model opens grant windows and queues expected completions.
// A negedge monitor checks grant, select and payload on every cycle, and pops the queue on each Done.
module tb_rr_bus_arbiter4;

  localparam int L    = 2;
  localparam int LM   = 4;
  localparam int NCYC = 4000;
  localparam int LAST = NCYC + L + 4;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    int due;
    int who;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  Req, Lock;
  logic [31:0] pay [4];
  logic [3:0]  Grant, Done;
  logic [1:0]  Sel;
  logic [31:0] Out;
  logic        Busy;

  always #5 Clk = ~Clk;

  rr_bus_arbiter4 #(.LATENCY(L), .LOCK_MAX(LM)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Req   (Req),
    .Lock  (Lock),
    .InA   (pay[0]),
    .InB   (pay[1]),
    .InC   (pay[2]),
    .InD   (pay[3]),
    .Grant (Grant),
    .Sel   (Sel),
    .Out   (Out),
    .Done  (Done),
    .Busy  (Busy)
  );

  int   vectors, miscompares;
  int   n;
  bit   fin;
  int   exp_own [0:LAST+L+8];
  int   exp_sel [0:LAST+L+8];
  exp_t sbq [$];
  exp_t e;
  logic [3:0] eg;

  // Reference model state: the current window [m_start, m_done], its owner, the pointer and the lock run.
  int m_ptr, m_sel, m_own, m_start, m_done, m_lock, rst_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  task automatic open_window(input int c, input int who);
    m_own   = who;
    m_sel   = who;
    m_start = c + 1;
    m_done  = c + L;
    for (int t = c + 1; t <= c + L; t++) exp_own[t] = who;
    sbq.push_back('{c + L, who});
  endtask

  task automatic model_step(input int c, input logic rst);
    bit cont;
    bit found;
    cont  = 1'b0;
    found = 1'b0;
    exp_sel[c] = m_sel;
    if (rst) begin
      m_ptr = 0; m_sel = 0; m_done = -1; m_start = 0; m_lock = 0;
      for (int t = c + 1; t <= c + L + 1; t++) exp_own[t] = -1;
      while (sbq.size() > 0 && sbq[$].due > c) void'(sbq.pop_back());
    end else begin
      if (c == m_done) begin
        m_ptr = (m_own + 1) % 4;
        if (LOCK_EN && Lock[m_own] && Req[m_own] && m_lock < LM - 1) begin
          cont = 1'b1;
          m_lock++;
          open_window(c, m_own);
        end
      end
      if (!cont && m_done <= c) begin
        for (int k = 0; k < 4; k++) begin
          if (!found && Req[(m_ptr + k) % 4]) begin
            found  = 1'b1;
            m_lock = 0;
            open_window(c, (m_ptr + k) % 4);
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      if (n >= 1 && !fin) begin
        eg = (exp_own[n] < 0) ? 4'b0000 : (4'b0001 << exp_own[n]);
        check("grant", {28'd0, Grant}, {28'd0, eg});
        check("busy", {31'd0, Busy}, (exp_own[n] >= 0) ? 32'd1 : 32'd0);
        check("sel", {30'd0, Sel}, exp_sel[n]);
        check("out", Out, pay[exp_sel[n]]);
        while (sbq.size() > 0 && sbq[0].due < n) begin
          check("done_missing", n, sbq[0].due);
          void'(sbq.pop_front());
        end
        if (Done != 4'b0000) begin
          if (sbq.size() == 0) begin
            check("done_spurious", {28'd0, Done}, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("done_cycle", n, e.due);
            check("done_who", {28'd0, Done}, 32'd1 << e.who);
          end
        end
      end
    end
  end

  initial begin
    vectors = 0; miscompares = 0; fin = 1'b0; n = 0;
    for (int i = 0; i <= LAST + L + 8; i++) begin
      exp_own[i] = -1;
      exp_sel[i] = 0;
    end
    m_ptr = 0; m_sel = 0; m_own = 0; m_start = 0; m_done = -1; m_lock = 0; rst_cnt = 0;
    Reset = 1'b1; Req = 4'b0; Lock = 4'b0;
    for (int i = 0; i < 4; i++) pay[i] = $urandom;
    model_step(0, 1'b1);

    for (int c = 1; c < LAST; c++) begin
      @(posedge Clk);
      #1;
      n = c;
      for (int i = 0; i < 4; i++) pay[i] = $urandom;
      if (c < 2) begin
        Reset = 1'b1;
      end else if (c < NCYC && m_start == c && m_done >= c && rst_cnt < 6 &&
                   $urandom_range(0, 9) == 0) begin
        Reset = 1'b1;
        rst_cnt++;
      end else begin
        Reset = 1'b0;
      end
      // A requester holds Req until its window ends and may drop it early inside the window.
      for (int r = 0; r < 4; r++) begin
        if (c >= NCYC) begin
          Req[r] = 1'b0;
        end else if (m_own == r && m_start <= c && c <= m_done) begin
          if (c == m_done) Req[r] = 1'($urandom_range(0, 1));
          else if ($urandom_range(0, 3) == 0) Req[r] = 1'b0;
        end else if (!Req[r]) begin
          Req[r] = ($urandom_range(0, 2) == 0);
        end
      end
      Lock = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
      model_step(c, Reset);
    end

    @(negedge Clk);
    #1;
    check("queue_drained", sbq.size(), 0);
    fin = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
